m6502_alu_unit: RTL
===================

Name: m6502_alu_unit

Overview:
- Parametrised, handshaked ALU execution unit for the M6502 core. It replaces the combinational ALU with a registered unit.
- Supports a generic data width and optional BCD arithmetic (decimal mode, off by default to match the 2A03).
- Returns the result together with per-flag write enables, so the status register applies only the affected C/Z/V/N bits.
- Sits between the core sequencer (operand and opcode source) and the register file / status register.

Parameters:
- DATA_WIDTH, 8, operand/result width; must be a multiple of 4 and at least 8.
- DECIMAL_EN, 0, 1 = ADC/SBC honour in_decimal (BCD); 0 = in_decimal ignored.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit accepts request this cycle.
- in_op  input  4  operation code: 0 ADC, 1 INC, 2 DEC, 3 SBC, 4 CMP, 5 AND, 6 OR, 7 EOR, 8 ASL, 9 ROL, 10 ROR, 11 LSR.
- in_a  input  DATA_WIDTH  operand A; the only operand for unary ops.
- in_b  input  DATA_WIDTH  operand B.
- in_carry  input  1  carry flag in.
- in_decimal  input  1  decimal flag in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  DATA_WIDTH  result.
- out_result_we  output  1  result is to be written back.
- out_flags  output  4  {N,V,Z,C}.
- out_flags_we  output  4  per-flag write enable, same bit order as out_flags.

Behaviour:
- Reset: rst_n sampled low on a clk edge puts the FSM in IDLE. All outputs are 0, including in_ready, which stays 0 while rst_n is low and rises the cycle after release. Reset aborts any op in flight and discards any pending result.
- States and transitions:
  - IDLE: in_ready=1, out_valid=0. Accept on in_valid: binary op goes to HOLD; decimal op (DECIMAL_EN=1, in_decimal=1, op ADC/SBC) goes to ADJ.
  - ADJ: one cycle of BCD correction; in_ready=0; then HOLD.
  - HOLD: out_valid=1 and outputs held stable; in_ready=out_ready.
    - out_ready=1 with in_valid=1: retire the current result and accept the new request in the same cycle (HOLD or ADJ per the new op).
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=0: stay in HOLD.
- Latency and throughput: binary ops have out_valid the cycle after acceptance; decimal ops two cycles after. Binary ops sustain 1 op/cycle under continuous out_ready.
- Arithmetic (W=DATA_WIDTH, MSB=W-1; all results wrap modulo 2^W):
  - ADC: sum=A+B+Cin; C=carry out of MSB; V=(A[MSB]==B[MSB])&&(sum[MSB]!=A[MSB]); we N,V,Z,C.
  - SBC: ADC with ~B.
  - CMP: A-B; C=(A>=B unsigned); result_we=0; we N,Z,C.
  - INC/DEC: A±1; we N,Z.
  - AND/OR/EOR: bitwise; we N,Z.
  - ASL: A<<1, C=A[MSB].
  - ROL: {A[MSB-1:0],Cin}, C=A[MSB].
  - ROR: {Cin,A[MSB:1]}, C=A[0].
  - LSR: {0,A[MSB:1]}, C=A[0].
  - All shifts/rotates: we N,Z,C.
  - Z=(result==0); N=result[MSB].
  - result_we=1 for every valid op except CMP.
- Decimal mode, applied per 4-bit nibble LSB→MSB:
  - ADC: a nibble sum >9 (or carrying out) is corrected by +6 and propagates carry; C=carry out of the top nibble.
  - SBC: a nibble that borrowed is corrected by −6; C=binary no-borrow.
  - N,V,Z come from the binary (uncorrected) sum, per NMOS behaviour.
  - Invalid BCD inputs are not an error; the result is whatever the nibble algorithm produces.
- in_op 12–15: one-cycle op; out_result=in_a, result_we=0, flags_we=0.
- Operands are captured at acceptance; later changes on in_* do not affect the op in flight.

Test Plan:
- ADC A=0x50, B=0x50, Cin=0 → result 0xA0; N=1, V=1, Z=0, C=0; flags_we=4'hF; out_valid one cycle after accept.
- DECIMAL_EN=1, D=1: ADC 0x19+0x28 → 0x47, C=0, out_valid two cycles after accept. ADC 0x99+0x01 → 0x00, C=1. With D=0 the same 0x99+0x01 → 0x9A, C=0, one-cycle latency.
- CMP A=0x10, B=0x20 → C=0, N=1, Z=0, result_we=0, flags_we={N,Z,C}. ROR A=0x01, Cin=1 → 0x80, C=1, N=1.
- Backpressure: accept ADC, hold out_ready=0 for 3 cycles → outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 → new op accepted in that same cycle. Continue 8 back-to-back INCs → 8 results on consecutive cycles.
- DATA_WIDTH=16: INC 0xFFFF → 0x0000, Z=1, C not written (flags_we C bit=0). in_op=13 → result_we=0, flags_we=0.
- Reset in ADJ, and separately in HOLD → next cycle out_valid=0, in_ready=0; the cycle after release in_ready=1; the aborted result never appears.

Source files
------------

// File: rtl/m6502_alu_unit.sv
// m6502_alu_unit: registered, handshaked M6502 ALU with optional BCD correction stage
module m6502_alu_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int DECIMAL_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_carry,
    input  logic                  in_decimal,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_result_we,
    output logic [3:0]            out_flags,
    output logic [3:0]            out_flags_we
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, ADJ, HOLD} state_t;
    state_t state_q, state_d;
    logic run_q;
    logic [W-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
    logic [3:0] flags_q, flags_d, flags_we_q, flags_we_d, fwe;
    logic result_we_q, result_we_d, c_q, c_d, sub_q, sub_d, rwe;
    logic acc, dec, sub, cmp, bin_c, bin_v, dec_c, nib_c;
    logic [W-1:0] bb, res, dec_res;
    logic [W:0] sum;
    logic [4:0] s;

    assign in_ready = run_q && (state_q == IDLE || (state_q == HOLD && out_ready));
    assign acc = in_valid && in_ready;
    assign sub = in_op == 4'd3;
    assign cmp = in_op == 4'd4;
    assign dec = DECIMAL_EN != 0 && in_decimal && (in_op == 4'd0 || sub);
    assign bb = (sub || cmp) ? ~in_b : in_b;
    assign sum = {1'b0, in_a} + {1'b0, bb} + {{W{1'b0}}, cmp | in_carry};
    assign bin_v = (in_a[W-1] == bb[W-1]) && (sum[W-1] != in_a[W-1]);
    assign out_valid = state_q == HOLD;
    assign out_result = result_q;
    assign out_result_we = result_we_q;
    assign out_flags = flags_q;
    assign out_flags_we = flags_we_q;

    always_comb begin
        res = in_a;
        bin_c = sum[W];
        rwe = 1'b1;
        fwe = 4'b1010;
        case (in_op)
            4'd0, 4'd3: begin res = sum[W-1:0]; fwe = 4'b1111; end
            4'd1: res = in_a + W'(1);
            4'd2: res = in_a - W'(1);
            4'd4: begin res = sum[W-1:0]; rwe = 1'b0; fwe = 4'b1011; end
            4'd5: res = in_a & in_b;
            4'd6: res = in_a | in_b;
            4'd7: res = in_a ^ in_b;
            4'd8: begin res = {in_a[W-2:0], 1'b0}; bin_c = in_a[W-1]; fwe = 4'b1011; end
            4'd9: begin res = {in_a[W-2:0], in_carry}; bin_c = in_a[W-1]; fwe = 4'b1011; end
            4'd10: begin res = {in_carry, in_a[W-1:1]}; bin_c = in_a[0]; fwe = 4'b1011; end
            4'd11: begin res = {1'b0, in_a[W-1:1]}; bin_c = in_a[0]; fwe = 4'b1011; end
            default: begin rwe = 1'b0; fwe = 4'b0000; end
        endcase
    end

    always_comb begin
        dec_res = '0;
        nib_c = c_q;
        s = '0;
        for (int i = 0; i < W / 4; i++) begin
            if (sub_q) begin
                s = {1'b0, a_q[4*i +: 4]} - {1'b0, b_q[4*i +: 4]} - {4'b0, ~nib_c};
                nib_c = !s[4];
                if (s[4]) s = s - 5'd6;
            end else begin
                s = {1'b0, a_q[4*i +: 4]} + {1'b0, b_q[4*i +: 4]} + {4'b0, nib_c};
                nib_c = s > 5'd9;
                if (nib_c) s = s + 5'd6;
            end
            dec_res[4*i +: 4] = s[3:0];
        end
        dec_c = nib_c;
    end

    always_comb begin
        state_d = acc ? (dec ? ADJ : HOLD) :
                  (state_q == ADJ || (state_q == HOLD && !out_ready)) ? HOLD : IDLE;
        result_d = acc ? res : (state_q == ADJ) ? dec_res : result_q;
        flags_d = acc ? {res[W-1], bin_v, res == '0, bin_c} :
                  (state_q == ADJ && !sub_q) ? {flags_q[3:1], dec_c} : flags_q;
        result_we_d = acc ? rwe : result_we_q;
        flags_we_d = acc ? fwe : flags_we_q;
        a_d = acc ? in_a : a_q;
        b_d = acc ? in_b : b_q;
        c_d = acc ? in_carry : c_q;
        sub_d = acc ? sub : sub_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q <= 1'b0;
            result_q <= '0;
            flags_q <= '0;
            result_we_q <= 1'b0;
            flags_we_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            sub_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q <= 1'b1;
            result_q <= result_d;
            flags_q <= flags_d;
            result_we_q <= result_we_d;
            flags_we_q <= flags_we_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            sub_q <= sub_d;
        end
    end
endmodule
